// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and bit-period math used by both rx and tx.
package uart_pkg;
    localparam int DATA_BITS = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
    function automatic int baud_clocks(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received character and status out.
interface uart_rx_if;
    import uart_pkg::*;
    logic                 rx_in;
    logic [DATA_BITS-1:0] dout;
    logic                 data_strobe;
    logic                 rx_error;
    logic                 busy;
    modport master (output rx_in, input dout, data_strobe, rx_error, busy);
    modport slave  (input rx_in, output dout, data_strobe, rx_error, busy);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous input, programmable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        if (!rst) {q, meta} <= {RESET_VAL, RESET_VAL};
        else      {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1/8O1/8E1 serial receiver sampling each bit at mid-period.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200,
    parameter int PARITY_EN     = 1,
    parameter int PARITY_ODD    = 1
) (
    input logic        clk,
    input logic        rst,
    uart_rx_if.slave   bus
);
    localparam int BAUD_CLOCKS = baud_clocks(CLK_FREQUENCY, BAUD_RATE);
    localparam int HALF_BAUD   = BAUD_CLOCKS / 2;
    localparam int CW          = $clog2(BAUD_CLOCKS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CLOCKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BAUD - 1);
    localparam logic ODD = PARITY_ODD != 0;

    rx_state_t            state, state_n;
    logic                 rx_sync, rx_prev;
    logic [CW-1:0]        cnt;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shift, dout;
    logic                 parity_err, rx_error, data_strobe;
    logic                 half_tick, full_tick;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(bus.rx_in), .q(rx_sync));

    assign half_tick       = cnt == HALF_LAST;
    assign full_tick       = cnt == BAUD_LAST;
    assign bus.dout        = dout;
    assign bus.rx_error    = rx_error;
    assign bus.data_strobe = data_strobe;
    assign bus.busy        = state != IDLE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (rx_prev && !rx_sync) ? START : IDLE;
            START:   if (half_tick) state_n = rx_sync ? IDLE : DATA;
            DATA:    if (full_tick && idx == 3'(DATA_BITS - 1)) state_n = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (full_tick) state_n = STOP;
            STOP:    if (full_tick) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            rx_prev     <= 1'b1;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            parity_err  <= 1'b0;
            dout        <= '0;
            rx_error    <= 1'b0;
            data_strobe <= 1'b0;
        end else begin
            state       <= state_n;
            rx_prev     <= rx_sync;
            data_strobe <= 1'b0;
            cnt         <= (state == IDLE || state_n != state || full_tick) ? '0 : cnt + CW'(1);
            if (state == IDLE) parity_err <= 1'b0;
            if (state == START) idx <= '0;
            if (state == DATA && full_tick) begin
                shift <= {rx_sync, shift[DATA_BITS-1:1]};
                idx   <= idx + 3'd1;
            end
            if (state == PARITY && full_tick) parity_err <= ((^shift) ^ rx_sync) != ODD;
            // Leaving at mid stop bit lets a following start edge be caught with no idle gap.
            if (state == STOP && full_tick) begin
                dout        <= shift;
                rx_error    <= parity_err | ~rx_sync;
                data_strobe <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame tests for uart_rx at 32 clocks per bit.
module tb_uart_rx;
    localparam int CLK_F = 3_200_000;
    localparam int BAUD  = 100_000;
    localparam int B     = 32;
    localparam int H     = 16;
    localparam int LAT   = 2 + H + 10 * B + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0, errors = 0, cyc = 0, strobes = 0, last_cyc = 0;
    logic [7:0] got_q[$];
    logic last_err = 1'b0;
    logic [7:0] vec [20] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h5A, 8'hA5, 8'h7E, 8'h81, 8'h33, 8'hCC,
                             8'h0F, 8'hF0, 8'h96, 8'h69, 8'h42, 8'hBD, 8'h11, 8'hEE, 8'h7F, 8'hFE};

    uart_rx_if bus();
    uart_rx #(.CLK_FREQUENCY(CLK_F), .BAUD_RATE(BAUD), .PARITY_EN(1), .PARITY_ODD(1))
        dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;
    always @(negedge clk) begin
        if (bus.data_strobe === 1'b1) begin
            strobes = strobes + 1;
            got_q.push_back(bus.dout);
            last_err = bus.rx_error;
            last_cyc = cyc;
        end
    end

    task automatic drive(input logic v, input int n);
        bus.rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic bad_par, input logic stop_v);
        drive(1'b0, B);
        for (int i = 0; i < 8; i++) drive(d[i], B);
        drive(~^d ^ bad_par, B);
        drive(stop_v, B);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.rx_in = 1'b1;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", bus.dout); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.data_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", bus.data_strobe); end
        checks++; if (bus.rx_error !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.rx_error); end
        drive(1'b1, 10 * B);
        checks++; if (strobes !== 0) begin errors++; $display("FAIL idle_strobes got %0d exp 0", strobes); end
    endtask

    task automatic test_basic;
        int n0, t0;
        n0 = strobes;
        t0 = cyc;
        send(8'hA5, 1'b0, 1'b1);
        drive(1'b1, 4);
        checks++; if (strobes - n0 !== 1) begin errors++; $display("FAIL basic_count got %0d exp 1", strobes - n0); end
        checks++; if (got_q[$] !== 8'hA5) begin errors++; $display("FAIL basic_dout got %h exp a5", got_q[$]); end
        checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", last_err); end
        checks++; if (last_cyc - t0 < LAT - 2 || last_cyc - t0 > LAT + 2) begin
            errors++; $display("FAIL basic_latency got %0d exp %0d+-2", last_cyc - t0, LAT);
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_stream;
        for (int i = 0; i < 20; i++) begin
            send(vec[i], 1'b0, 1'b1);
            checks++; if (got_q[$] !== vec[i] || last_err !== 1'b0) begin
                errors++; $display("FAIL stream_%0d got %h/%b exp %h/0", i, got_q[$], last_err, vec[i]);
            end
            drive(1'b1, $urandom_range(10, 300));
        end
    endtask

    task automatic test_parity_error;
        send(8'h3C, 1'b1, 1'b1);
        drive(1'b1, 20);
        checks++; if (got_q[$] !== 8'h3C) begin errors++; $display("FAIL par_dout got %h exp 3c", got_q[$]); end
        checks++; if (last_err !== 1'b1) begin errors++; $display("FAIL par_err got %b exp 1", last_err); end
        send(8'h55, 1'b0, 1'b1);
        drive(1'b1, 20);
        checks++; if (got_q[$] !== 8'h55) begin errors++; $display("FAIL par_next_dout got %h exp 55", got_q[$]); end
        checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL par_next_err got %b exp 0", last_err); end
    endtask

    task automatic test_framing;
        int n0;
        n0 = strobes;
        send(8'hFF, 1'b0, 1'b0);
        drive(1'b0, 2 * B);
        checks++; if (strobes - n0 !== 1) begin errors++; $display("FAIL frame_count got %0d exp 1", strobes - n0); end
        checks++; if (got_q[$] !== 8'hFF) begin errors++; $display("FAIL frame_dout got %h exp ff", got_q[$]); end
        checks++; if (last_err !== 1'b1) begin errors++; $display("FAIL frame_err got %b exp 1", last_err); end
        drive(1'b1, 2 * B);
        checks++; if (strobes - n0 !== 1) begin errors++; $display("FAIL frame_rearm got %0d exp 1", strobes - n0); end
        send(8'h12, 1'b0, 1'b1);
        drive(1'b1, 20);
        checks++; if (strobes - n0 !== 2) begin errors++; $display("FAIL frame_next_count got %0d exp 2", strobes - n0); end
        checks++; if (got_q[$] !== 8'h12) begin errors++; $display("FAIL frame_next_dout got %h exp 12", got_q[$]); end
        checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL frame_next_err got %b exp 0", last_err); end
    endtask

    task automatic test_glitch;
        int n0;
        logic saw;
        n0 = strobes;
        saw = 1'b0;
        bus.rx_in = 1'b0;
        repeat (3) begin @(negedge clk); saw |= bus.busy; end
        bus.rx_in = 1'b1;
        repeat (2 * B) begin @(negedge clk); saw |= bus.busy; end
        @(posedge clk);
        #1;
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse got %b exp 1", saw); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b exp 0", bus.busy); end
        checks++; if (strobes !== n0) begin errors++; $display("FAIL glitch_strobe got %0d exp %0d", strobes, n0); end
    endtask

    task automatic test_back_to_back;
        int n0;
        n0 = strobes;
        send(8'h01, 1'b0, 1'b1);
        send(8'h80, 1'b0, 1'b1);
        drive(1'b1, 20);
        checks++; if (strobes - n0 !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", strobes - n0); end
        checks++; if (got_q[$-1] !== 8'h01) begin errors++; $display("FAIL b2b_first got %h exp 01", got_q[$-1]); end
        checks++; if (got_q[$] !== 8'h80) begin errors++; $display("FAIL b2b_second got %h exp 80", got_q[$]); end
    endtask

    task automatic test_reset_mid;
        int n0;
        n0 = strobes;
        drive(1'b0, B);
        drive(1'b1, B);
        drive(1'b1, B);
        drive(1'b0, B);
        rst = 1'b0;
        bus.rx_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", bus.busy); end
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL mid_dout got %h exp 00", bus.dout); end
        @(posedge clk);
        #1;
        checks++; if (bus.data_strobe !== 1'b0) begin errors++; $display("FAIL mid_strobe got %b exp 0", bus.data_strobe); end
        drive(1'b1, 12 * B);
        checks++; if (strobes !== n0) begin errors++; $display("FAIL mid_no_char got %0d exp %0d", strobes, n0); end
        send(8'hC3, 1'b0, 1'b1);
        drive(1'b1, 20);
        checks++; if (got_q[$] !== 8'hC3) begin errors++; $display("FAIL mid_clean_dout got %h exp c3", got_q[$]); end
        checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL mid_clean_err got %b exp 0", last_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_parity_error();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
